mem_access_unit: RTL

Parametrised, multi-cycle memory access stage for the accumulator datapath. It owns the PC, IR and MDR registers, selects the memory address and write data, and drives an external synchronous memory with a configurable read latency through a Start/Busy/Done handshake. PC updates requested during an access are held and applied when the access ends. Out-of-range addresses raise a sticky overflow flag instead of touching memory.

---
 rtl/mem_access_unit.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: multi-cycle memory access stage owning the PC, IR and MDR.
// Drives a synchronous memory with a LATENCY-cycle read through Start/Busy/Done.
//
//   state  | meaning
//   IDLE   | waiting for Start
//   ACCESS | memory strobe active, Busy high, PC updates held as pending
//   DONE   | one-cycle completion pulse; a new Start is accepted here too
module mem_access_unit #(
  parameter int              WIDTH    = 16,
  parameter int              ADDR_W   = 16,
  parameter int              DEPTH    = 1024,
  parameter int              LATENCY  = 1,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Start,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              IRWrite,
  input  logic [1:0]        IorD,
  input  logic [1:0]        DataSrc,
  input  logic              PCWrite,
  input  logic              Jump,
  input  logic              Branch,
  input  logic              ShouldBranchIn,
  input  logic [WIDTH-1:0]  PCInput,
  input  logic [WIDTH-1:0]  ImmIn,
  input  logic [WIDTH-1:0]  ALUOutIn,
  input  logic [WIDTH-1:0]  SPIn,
  input  logic [WIDTH-1:0]  RegAIn,
  input  logic [WIDTH-1:0]  InputIO,
  input  logic [WIDTH-1:0]  MemRData,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [WIDTH-1:0]  MemWData,
  output logic              MemRE,
  output logic              MemWE,
  output logic [WIDTH-1:0]  PCOut,
  output logic [WIDTH-1:0]  IROut,
  output logic [WIDTH-1:0]  MDROut,
  output logic              Busy,
  output logic              Done,
  output logic              Overflow
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic              rd_q, irw_q;
  logic [WIDTH-1:0]  pend_pc;
  logic              pend_v;
  logic [WIDTH-1:0]  src_sel, wdata_sel;
  logic [ADDR_W-1:0] addr_sel;
  logic              src_ovf, accept, last_cycle, pcen;

  assign pcen = PCWrite | Jump | (Branch & ShouldBranchIn);

  // address/data source selection; range check uses the full source value
  always_comb begin
    case (IorD)
      2'b00:   src_sel = PCOut;
      2'b01:   src_sel = ImmIn;
      2'b10:   src_sel = ALUOutIn;
      default: src_sel = SPIn;
    endcase
    case (DataSrc)
      2'b00:   wdata_sel = PCOut;
      2'b01:   wdata_sel = RegAIn;
      2'b10:   wdata_sel = InputIO;
      default: wdata_sel = '0;
    endcase
    src_ovf = ({32'b0, src_sel} >= (WIDTH + 32)'(DEPTH));
  end

  generate
    if (ADDR_W <= WIDTH) begin : g_trunc
      assign addr_sel = src_sel[ADDR_W-1:0];
    end else begin : g_zext
      assign addr_sel = {{(ADDR_W - WIDTH){1'b0}}, src_sel};
    end
  endgenerate

  // state register
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // next state and handshake outputs
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    last_cycle = 1'b0;
    Busy       = 1'b0;
    Done       = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        Done = (state == S_DONE);
        if (Start) begin
          accept = 1'b1;
          if (!src_ovf && (MemRead || MemWrite)) state_nxt = S_ACCESS;
          else                                   state_nxt = S_DONE;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_ACCESS: begin
        Busy = 1'b1;
        if (cnt == 4'd0) begin
          last_cycle = 1'b1;
          state_nxt  = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // access launch, latency down-counter, strobes and IR/MDR capture
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      MemAddr  <= '0;
      MemWData <= '0;
      MemRE    <= 1'b0;
      MemWE    <= 1'b0;
      IROut    <= '0;
      MDROut   <= '0;
      Overflow <= 1'b0;
      cnt      <= '0;
      rd_q     <= 1'b0;
      irw_q    <= 1'b0;
    end else if (accept) begin
      MemAddr  <= addr_sel;
      MemWData <= wdata_sel;
      rd_q     <= MemRead & ~MemWrite;
      irw_q    <= IRWrite;
      // a write occupies a single ACCESS cycle
      cnt      <= MemWrite ? 4'd0 : 4'(LATENCY - 1);
      MemRE    <= ~src_ovf & ~MemWrite & MemRead;
      MemWE    <= ~src_ovf & MemWrite;
      if (src_ovf) Overflow <= 1'b1;
    end else if (last_cycle) begin
      MemRE <= 1'b0;
      MemWE <= 1'b0;
      if (rd_q) begin
        MDROut <= MemRData;
        if (irw_q) IROut <= MemRData;
      end
    end else if (state == S_ACCESS) begin
      cnt <= cnt - 4'd1;
    end
  end

  // PC update; requests during ACCESS are held and applied on exit, latest wins
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      PCOut   <= RESET_PC;
      pend_pc <= '0;
      pend_v  <= 1'b0;
    end else if (state == S_ACCESS) begin
      if (last_cycle) begin
        if (pcen)        PCOut <= PCInput;
        else if (pend_v) PCOut <= pend_pc;
        pend_pc <= '0;
        pend_v  <= 1'b0;
      end else if (pcen) begin
        pend_pc <= PCInput;
        pend_v  <= 1'b1;
      end
    end else if (pcen) begin
      PCOut <= PCInput;
    end
  end

endmodule
